wash_setting_selector: RTL and testbench
========================================

Name: wash_setting_selector

Overview:
- Parametrised successor to the per-mode temperature incrementor. Holds a user-adjustable level index for one wash setting (temperature, spin speed, rinse count), initialised from a per-mode default table.
- Steps the index up or down on button edges, with wrap or saturate behaviour.
- Reloads the mode default when the wash mode changes, and freezes while a cycle is running.
- Sits between the front-panel button debouncers and the wash controller; one instance per adjustable setting.

Parameters:
- NUM_LEVELS, 4, number of selectable levels (2..16).
- IDX_W, 2, index width; must satisfy 2**IDX_W >= NUM_LEVELS.
- LEVEL_W, 7, width of each level value.
- LEVEL_TABLE, {7'd60,7'd40,7'd30,7'd10}, packed level values; entry i at [i*LEVEL_W +: LEVEL_W].
- NUM_MODES, 8, number of wash modes.
- MODE_W, 3, wash_mode width.
- DEFAULT_TABLE, 16'hA63A, packed default index per mode; entry m at [m*IDX_W +: IDX_W]. The default decodes as modes 0..7 = 2,2,3,0,2,1,2,2.
- WRAP, 1, 1 = wrap around at the ends, 0 = saturate at the ends.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- wash_mode  input  MODE_W  selected wash mode.
- increment  input  1  level-up button, debounced level.
- decrement  input  1  level-down button, debounced level.
- lock  input  1  high while a wash cycle runs; adjustment inhibited.
- selected_value  output  LEVEL_W  LEVEL_TABLE entry at index (combinational from index).
- index  output  IDX_W  current level index (registered).
- at_min  output  1  index == 0.
- at_max  output  1  index == NUM_LEVELS-1.
- changed  output  1  one-cycle pulse, the cycle after index changes for any reason other than reset.

Behaviour:
- Default lookup def(m):
  - DEFAULT_TABLE entry m.
  - If m >= NUM_MODES, or the entry is >= NUM_LEVELS, def(m) = 0.
- Reset (reset==0 at posedge):
  - index <= def(wash_mode); inc_prev, dec_prev <= 0; mode_prev <= wash_mode; changed <= 0.
  - Repeat state idles.
  - Reset overrides everything, including mid-hold.
- Edge detect:
  - inc_rise = increment & ~inc_prev; dec_rise = decrement & ~dec_prev.
  - Prev registers update every non-reset cycle, even when locked, so releasing the lock never yields a phantom edge.
- Priority per cycle, highest first:
  - (1) Mode reload: wash_mode != mode_prev and lock==0 → index <= def(wash_mode). Button edges in the same cycle are discarded.
  - (2) lock==1 → index holds; mode_prev does NOT update while locked. A mode change under lock is therefore applied on the first unlocked cycle.
  - (3) inc_rise & dec_rise → no change.
  - (4) inc_rise → step up. (5) dec_rise → step down.
- Step arithmetic:
  - Up: index==NUM_LEVELS-1 → 0 if WRAP, else hold. Otherwise index+1.
  - Down: index==0 → NUM_LEVELS-1 if WRAP, else hold.
  - A saturated step that holds does not assert changed.
- Latency:
  - A rising edge sampled at posedge k updates index at posedge k; selected_value is valid after that edge.
  - changed is high for cycle k+1.
- mode_prev <= wash_mode on every unlocked non-reset cycle.
- A held button produces exactly one step unless the optional feature is enabled.

Optional Feature:
- Macro AUTO_REPEAT_EN, adding parameters REPEAT_DELAY (default 50) and REPEAT_PERIOD (default 10), in clk cycles.
- When defined, a 3-state FSM runs per direction:
  - IDLE → HOLD on a step edge.
  - HOLD → REPEAT after the button stays high for REPEAT_DELAY cycles; one step is issued on entry.
  - REPEAT issues one step every REPEAT_PERIOD cycles.
  - Any state → IDLE on button release, lock, mode reload, both buttons high, or reset.
  - Repeat steps follow the WRAP/saturate rules.
- When not defined: no counters or FSM are built, and a held button gives a single step.

Test Plan:
- Reset with wash_mode=2, default params → index=3, selected_value=60, at_max=1.
- From index 3, one increment pulse → index=0, selected_value=10, changed pulse 1 cycle. With WRAP=0 → stays 60, changed=0.
- increment and decrement rise in the same cycle at index 2 → index stays 2, selected_value 40.
- lock=1, toggle increment 3 times, wash_mode 0→5, then lock=0 → no change while locked; on the first unlocked cycle index=1 (30), changed pulses.
- Hold increment high 200 cycles from index 0 → exactly one step (index 1) without macro. With AUTO_REPEAT_EN (50/10) → step at the edge, then at cycle 50, then every 10 cycles, wrapping 3→0.
- Assert reset mid-repeat with wash_mode=3 → next cycle index=0, repeat FSM idle, changed=0.

Source files
------------

// File: rtl/wash_setting_selector.sv
// rtl/wash_setting_selector.sv - per-mode adjustable wash setting level index (optional AUTO_REPEAT_EN)
module wash_setting_selector #(
    parameter int NUM_LEVELS = 4,
    parameter int IDX_W = 2,
    parameter int LEVEL_W = 7,
    parameter logic [NUM_LEVELS*LEVEL_W-1:0] LEVEL_TABLE = {7'd60, 7'd40, 7'd30, 7'd10},
    parameter int NUM_MODES = 8,
    parameter int MODE_W = 3,
    parameter logic [NUM_MODES*IDX_W-1:0] DEFAULT_TABLE = 16'hA63A,
    parameter int WRAP = 1
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_PERIOD = 10
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MODE_W-1:0]  wash_mode,
    input  logic               increment,
    input  logic               decrement,
    input  logic               lock,
    output logic [LEVEL_W-1:0] selected_value,
    output logic [IDX_W-1:0]   index,
    output logic               at_min,
    output logic               at_max,
    output logic               changed
);

    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(NUM_LEVELS - 1);

    logic              inc_prev;
    logic              dec_prev;
    logic [MODE_W-1:0] mode_prev;
    logic [IDX_W-1:0]  index_next;
    logic [IDX_W-1:0]  def_index;
    logic [IDX_W-1:0]  def_entry;
    logic [IDX_W-1:0]  up_index;
    logic [IDX_W-1:0]  down_index;
    logic              inc_rise;
    logic              dec_rise;
    logic              reload;
    logic              step_up;
    logic              step_down;

    assign inc_rise = increment & ~inc_prev;
    assign dec_rise = decrement & ~dec_prev;
    assign reload   = (wash_mode != mode_prev) & ~lock;

    // Out-of-range modes and out-of-range table entries both fall back to level 0.
    always_comb begin
        def_entry = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (int'(wash_mode) == m) begin
                def_entry = DEFAULT_TABLE[m*IDX_W +: IDX_W];
            end
        end
        def_index = (int'(def_entry) < NUM_LEVELS) ? def_entry : '0;
    end

    always_comb begin
        selected_value = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (int'(index) == i) begin
                selected_value = LEVEL_TABLE[i*LEVEL_W +: LEVEL_W];
            end
        end
    end

    assign at_min = (index == '0);
    assign at_max = (index == LAST_INDEX);

    always_comb begin
        if (index == LAST_INDEX) begin
            up_index = (WRAP != 0) ? '0 : index;
        end else begin
            up_index = index + IDX_W'(1);
        end
        if (index == '0) begin
            down_index = (WRAP != 0) ? LAST_INDEX : index;
        end else begin
            down_index = index - IDX_W'(1);
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_HOLD,
        RPT_REPEAT
    } rpt_state_t;

    rpt_state_t       rpt_state [2];
    rpt_state_t       rpt_state_next [2];
    logic [CNT_W-1:0] rpt_cnt [2];
    logic [CNT_W-1:0] rpt_cnt_next [2];
    logic             rpt_step [2];
    logic             rpt_btn [2];
    logic             rpt_rise [2];
    logic             rpt_abort [2];

    // Index 0 tracks the increment button, index 1 the decrement button.
    always_comb begin
        rpt_btn[0]  = increment;
        rpt_btn[1]  = decrement;
        rpt_rise[0] = inc_rise;
        rpt_rise[1] = dec_rise;
        for (int d = 0; d < 2; d++) begin
            rpt_state_next[d] = rpt_state[d];
            rpt_cnt_next[d]   = rpt_cnt[d];
            rpt_step[d]       = 1'b0;
            rpt_abort[d]      = ~rpt_btn[d] | lock | reload | (increment & decrement);
            case (rpt_state[d])
                RPT_IDLE: begin
                    if (rpt_rise[d] && !rpt_abort[d]) begin
                        rpt_state_next[d] = RPT_HOLD;
                        rpt_cnt_next[d]   = '0;
                    end
                end
                RPT_HOLD: begin
                    if (rpt_abort[d]) begin
                        rpt_state_next[d] = RPT_IDLE;
                    end else if (rpt_cnt[d] == CNT_W'(REPEAT_DELAY - 1)) begin
                        rpt_state_next[d] = RPT_REPEAT;
                        rpt_cnt_next[d]   = '0;
                        rpt_step[d]       = 1'b1;
                    end else begin
                        rpt_cnt_next[d] = rpt_cnt[d] + CNT_W'(1);
                    end
                end
                RPT_REPEAT: begin
                    if (rpt_abort[d]) begin
                        rpt_state_next[d] = RPT_IDLE;
                    end else if (rpt_cnt[d] == CNT_W'(REPEAT_PERIOD - 1)) begin
                        rpt_cnt_next[d] = '0;
                        rpt_step[d]     = 1'b1;
                    end else begin
                        rpt_cnt_next[d] = rpt_cnt[d] + CNT_W'(1);
                    end
                end
                default: rpt_state_next[d] = RPT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                rpt_state[d] <= RPT_IDLE;
                rpt_cnt[d]   <= '0;
            end else begin
                rpt_state[d] <= rpt_state_next[d];
                rpt_cnt[d]   <= rpt_cnt_next[d];
            end
        end
    end

    assign step_up   = inc_rise | rpt_step[0];
    assign step_down = dec_rise | rpt_step[1];
`else
    assign step_up   = inc_rise;
    assign step_down = dec_rise;
`endif

    // A mode reload discards any button activity in the same cycle.
    always_comb begin
        index_next = index;
        if (reload) begin
            index_next = def_index;
        end else if (!lock) begin
            if (step_up && step_down) begin
                index_next = index;
            end else if (step_up) begin
                index_next = up_index;
            end else if (step_down) begin
                index_next = down_index;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            index     <= def_index;
            inc_prev  <= 1'b0;
            dec_prev  <= 1'b0;
            mode_prev <= wash_mode;
            changed   <= 1'b0;
        end else begin
            index    <= index_next;
            inc_prev <= increment;
            dec_prev <= decrement;
            changed  <= (index_next != index);
            // Holding mode_prev while locked defers a locked mode change to the unlock cycle.
            if (!lock) begin
                mode_prev <= wash_mode;
            end
        end
    end

endmodule

// File: tb/tb_wash_setting_selector.sv
// tb/tb_wash_setting_selector.sv - scoreboard bench for wash_setting_selector, wrap and saturate instances
module tb_wash_setting_selector;

    typedef struct packed {
        logic [1:0] idx;
        logic [6:0] val;
        logic       mn;
        logic       mx;
        logic       chg;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] wash_mode = 3'd0;
    logic       increment = 1'b0;
    logic       decrement = 1'b0;
    logic       lock = 1'b0;

    logic [6:0] value_w;
    logic [1:0] index_w;
    logic       at_min_w;
    logic       at_max_w;
    logic       changed_w;
    logic [6:0] value_s;
    logic [1:0] index_s;
    logic       at_min_s;
    logic       at_max_s;
    logic       changed_s;

    always #5 clk = ~clk;

    wash_setting_selector #(.WRAP(1)) dut_wrap (
        .clk(clk), .reset(reset), .wash_mode(wash_mode), .increment(increment),
        .decrement(decrement), .lock(lock), .selected_value(value_w), .index(index_w),
        .at_min(at_min_w), .at_max(at_max_w), .changed(changed_w)
    );

    wash_setting_selector #(.WRAP(0)) dut_sat (
        .clk(clk), .reset(reset), .wash_mode(wash_mode), .increment(increment),
        .decrement(decrement), .lock(lock), .selected_value(value_s), .index(index_s),
        .at_min(at_min_s), .at_max(at_max_s), .changed(changed_s)
    );

    // Reference tables written out as plain decoded numbers.
    int defaults [8] = '{2, 2, 3, 0, 2, 1, 2, 2};
    int levels [4]   = '{10, 30, 40, 60};

    int   m_idx [2];
    int   m_mode_prev;
    bit   m_inc_prev;
    bit   m_dec_prev;
    exp_t q_wrap [$];
    exp_t q_sat [$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    function automatic exp_t make_exp(int idx, bit chg);
        exp_t e;
        e.idx = 2'(idx);
        e.val = 7'(levels[idx]);
        e.mn  = (idx == 0);
        e.mx  = (idx == 3);
        e.chg = chg;
        return e;
    endfunction

    function automatic int step(int idx, bit up, bit wrap);
        int n;
        n = up ? idx + 1 : idx - 1;
        if (n > 3) n = wrap ? 0 : 3;
        if (n < 0) n = wrap ? 3 : 0;
        return n;
    endfunction

    task automatic cycle(input bit rst_n, input int mode, input bit inc, input bit dec, input bit lk);
        bit ir, dr;
        int nw;
        reset     = rst_n;
        wash_mode = 3'(mode);
        increment = inc;
        decrement = dec;
        lock      = lk;
        ir = inc && !m_inc_prev;
        dr = dec && !m_dec_prev;
        for (int k = 0; k < 2; k++) begin
            bit chg;
            if (!rst_n) begin
                nw  = defaults[mode];
                chg = 1'b0;
            end else begin
                nw = m_idx[k];
                if (mode != m_mode_prev && !lk) nw = defaults[mode];
                else if (lk || (ir && dr)) nw = m_idx[k];
                else if (ir) nw = step(m_idx[k], 1'b1, k == 0);
                else if (dr) nw = step(m_idx[k], 1'b0, k == 0);
                chg = (nw != m_idx[k]);
            end
            m_idx[k] = nw;
            if (k == 0) q_wrap.push_back(make_exp(nw, chg));
            else        q_sat.push_back(make_exp(nw, chg));
        end
        if (!rst_n) begin
            m_inc_prev  = 1'b0;
            m_dec_prev  = 1'b0;
            m_mode_prev = mode;
        end else begin
            m_inc_prev = inc;
            m_dec_prev = dec;
            if (!lk) m_mode_prev = mode;
        end
        @(negedge clk);
    endtask

    // Monitor: every posedge consumes one expected entry per instance.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q_wrap.size() > 0) begin
                e = q_wrap.pop_front();
                a = '{index_w, value_w, at_min_w, at_max_w, changed_w};
                checks++;
                if (a === e) passes++;
                else $display("FAIL wrap_outputs cycle %0d: got idx=%0d val=%0d min=%b max=%b chg=%b, want idx=%0d val=%0d min=%b max=%b chg=%b",
                              cyc, a.idx, a.val, a.mn, a.mx, a.chg, e.idx, e.val, e.mn, e.mx, e.chg);
            end
            if (q_sat.size() > 0) begin
                e = q_sat.pop_front();
                a = '{index_s, value_s, at_min_s, at_max_s, changed_s};
                checks++;
                if (a === e) passes++;
                else $display("FAIL sat_outputs cycle %0d: got idx=%0d val=%0d min=%b max=%b chg=%b, want idx=%0d val=%0d min=%b max=%b chg=%b",
                              cyc, a.idx, a.val, a.mn, a.mx, a.chg, e.idx, e.val, e.mn, e.mx, e.chg);
            end
        end
    end

    initial begin
        int mode;
        bit inc, dec, lk, rst;
        // Reset to mode 2, then step up past the top.
        cycle(0, 2, 0, 0, 0);
        cycle(1, 2, 0, 0, 0);
        cycle(1, 2, 1, 0, 0);
        cycle(1, 2, 0, 0, 0);
        cycle(1, 2, 0, 0, 0);
        // Down from the bottom on the wrap instance.
        cycle(1, 2, 0, 1, 0);
        cycle(1, 2, 0, 0, 0);
        // Simultaneous edges at index 2.
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 1, 1, 0);
        cycle(1, 0, 0, 0, 0);
        // Locked toggles and locked mode change, applied on unlock.
        cycle(1, 0, 0, 0, 1);
        for (int t = 0; t < 3; t++) begin
            cycle(1, 0, 1, 0, 1);
            cycle(1, 0, 0, 0, 1);
        end
        cycle(1, 5, 0, 0, 1);
        cycle(1, 5, 0, 0, 1);
        cycle(1, 5, 0, 0, 0);
        cycle(1, 5, 0, 0, 0);
        // Held button from index 0 gives one step.
        cycle(0, 3, 0, 0, 0);
        for (int t = 0; t < 200; t++) cycle(1, 3, 1, 0, 0);
        cycle(0, 3, 1, 0, 0);
        cycle(1, 3, 0, 0, 0);
        // Mode change with a button edge in the same cycle.
        cycle(1, 6, 0, 1, 0);
        cycle(1, 6, 0, 0, 0);
        // Randomised traffic.
        mode = 0;
        for (int t = 0; t < 3000; t++) begin
            rst = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, 7);
            inc = ($urandom_range(0, 2) == 0);
            dec = ($urandom_range(0, 2) == 0);
            lk  = ($urandom_range(0, 5) == 0);
            cycle(rst, mode, inc, dec, lk);
        end
        #3;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
